// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, 32-iteration shift-add MULTU with HI/LO, EX/MEM register
module ex_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [3:0]  in_alu_op,
    input  logic [31:0] in_read_data_1,
    input  logic [31:0] in_read_data_2,
    input  logic [31:0] in_imm,
    input  logic        in_alu_src,
    input  logic [4:0]  in_shamt,
    input  logic        in_reg_dst,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic        in_mem_to_reg,
    input  logic        in_mem_write,
    input  logic        in_mem_read,
    input  logic        in_reg_write,
    input  logic        in_branch,
    input  logic [1:0]  in_load_mode,
    output logic        stall,
    output logic [31:0] out_address,
    output logic [31:0] out_write_data,
    output logic        out_zero,
    output logic [4:0]  out_write_back_destination,
    output logic        out_mem_to_reg,
    output logic        out_mem_write,
    output logic        out_mem_read,
    output logic        out_reg_write,
    output logic        out_branch,
    output logic [1:0]  out_load_mode
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [3:0] OP_MULTU = 4'd8;

    state_t      state;
    state_t      state_next;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        accept;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [4:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;

    assign operand_b = in_alu_src ? in_imm : in_read_data_2;
    // Only IDLE accepts; DONE retires the held MULTU as a bubble.
    assign accept    = (state == IDLE) && in_valid && !stall;
    assign acc_next  = acc + (mplier[0] ? mcand : 64'd0);

    // Next-state and stall decode
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_alu_op == OP_MULTU) begin
                    stall      = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                stall = 1'b1;
                if (cnt == 5'd31) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ALU result selection
    always_comb begin
        result = 32'd0;
        case (in_alu_op)
            4'd0:    result = in_read_data_1 + operand_b;
            4'd1:    result = in_read_data_1 - operand_b;
            4'd2:    result = in_read_data_1 & operand_b;
            4'd3:    result = in_read_data_1 | operand_b;
            4'd4:    result = {31'd0, $signed(in_read_data_1) < $signed(operand_b)};
            4'd5:    result = ~(in_read_data_1 | operand_b);
            4'd6:    result = operand_b << in_shamt;
            4'd7:    result = operand_b >> in_shamt;
            4'd9:    result = hi;
            4'd10:   result = lo;
            default: result = 32'd0;
        endcase
    end

    // FSM state, multiplier iteration and HI/LO update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            acc    <= 64'd0;
            cnt    <= 5'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == MUL) begin
                mcand  <= {32'd0, in_read_data_1};
                mplier <= operand_b;
                acc    <= 64'd0;
                cnt    <= 5'd0;
            end else if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    hi <= acc_next[63:32];
                    lo <= acc_next[31:0];
                end
            end
        end
    end

    // EX/MEM register: loads the accepted instruction, otherwise a bubble
    always_ff @(posedge clk) begin
        if (!reset_n || !accept) begin
            out_address                <= 32'd0;
            out_write_data             <= 32'd0;
            out_zero                   <= 1'b0;
            out_write_back_destination <= 5'd0;
            out_mem_to_reg             <= 1'b0;
            out_mem_write              <= 1'b0;
            out_mem_read               <= 1'b0;
            out_reg_write              <= 1'b0;
            out_branch                 <= 1'b0;
            out_load_mode              <= 2'd0;
        end else begin
            out_address                <= result;
            out_write_data             <= in_read_data_2;
            out_zero                   <= (result == 32'd0);
            out_write_back_destination <= in_reg_dst ? in_rd : in_rt;
            out_mem_to_reg             <= in_mem_to_reg;
            out_mem_write              <= in_mem_write;
            out_mem_read               <= in_mem_read;
            out_reg_write              <= in_reg_write;
            out_branch                 <= in_branch;
            out_load_mode              <= in_load_mode;
        end
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low: clk  in  1  rising-edge clock; reset_n  in  1  synchronous active-low reset.
REQ-002 The block SHALL have these data inputs: in_valid in 1, instruction present; in_alu_op in 4, operation code; in_read_data_1 in 32, operand A; in_read_data_2 in 32, register operand B / store data; in_imm in 32, sign-extended immediate; in_alu_src in 1, 1 selects in_imm as B; in_shamt in 5, shift amount.
REQ-003 The block SHALL have these routing and control inputs: in_reg_dst in 1, 1 selects rd; in_rt in 5 and in_rd in 5, destination candidates; in_mem_to_reg, in_mem_write, in_mem_read, in_reg_write, in_branch in 1 each; in_load_mode in 2.
REQ-004 The block SHALL have these outputs: stall out 1, upstream hold request; out_address out 32, ALU result; out_write_data out 32, store data; out_zero out 1, result==0; out_write_back_destination out 5.
REQ-005 The block SHALL also output out_mem_to_reg, out_mem_write, out_mem_read, out_reg_write and out_branch (1 each) and out_load_mode (2), all registered, forming the EX/MEM register that feeds the memory stage.

Function
REQ-006 Operand B SHALL be in_imm when in_alu_src=1, else in_read_data_2.
REQ-007 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed, result 1/0), 5 NOR, 6 SLL (B<<in_shamt), 7 SRL (B>>in_shamt, logical), 8 MULTU, 9 MFHI, 10 MFLO; codes 11-15 SHALL yield result 0.
REQ-008 ADD/SUB SHALL wrap modulo 2^32, with no overflow trap.
REQ-009 A non-MULTU instruction accepted at edge k (in_valid=1, state IDLE) SHALL appear on all outputs after edge k, giving 1-cycle latency.
REQ-010 For an accepted instruction: out_address=result; out_write_data=in_read_data_2; out_zero=(result==0); out_write_back_destination=in_reg_dst?in_rd:in_rt; control outputs SHALL copy the inputs.
REQ-011 Bubble: when in_valid=0 or stall=1 at an edge, all outputs SHALL load 0.
REQ-012 The FSM SHALL have three states: IDLE, MUL, DONE.
REQ-013 stall SHALL be combinational: 1 when state=MUL, or when state=IDLE with in_valid=1 and in_alu_op=8; otherwise 0.
REQ-014 MULTU accepted at edge k SHALL capture A and B, clear the iteration counter, and go IDLE->MUL.
REQ-015 In MUL, the block SHALL perform one unsigned shift-add iteration per edge (edges k+1..k+32).
REQ-016 At edge k+32 the 64-bit product SHALL be written to HI (upper) and LO (lower), and the FSM SHALL go MUL->DONE.
REQ-017 stall SHALL be 1 for cycles k..k+32 (33 cycles) and 0 in the DONE cycle.
REQ-018 In DONE, the held MULTU SHALL retire as a bubble and SHALL NOT be re-accepted; the FSM SHALL go DONE->IDLE at the next edge regardless of inputs.
REQ-019 Upstream inputs are held stable while stall=1; the block SHALL ignore input changes during MUL.
REQ-020 MFHI/MFLO SHALL return the last completed HI/LO; 0 before any completed MULTU.
REQ-021 Multiply by 0 or by 0xFFFFFFFF SHALL still take the full 32 iterations, with no early exit.
REQ-022 MULTU SHALL NOT write the register file: out_reg_write SHALL stay 0 for the whole multiply.

Reset
REQ-023 When reset_n=0 at an edge, the block SHALL set state=IDLE, counter=0, HI=LO=0, and all registered outputs to 0; stall SHALL then follow REQ-013.
REQ-024 Reset during MUL SHALL abort the multiply with HI/LO=0 and no partial product visible.
REQ-025 Reset SHALL take priority over accept; an instruction presented during reset SHALL be discarded.

Verification
REQ-026 ADD A=0x7FFFFFFF, B=1, reg_write=1, reg_dst=1, rd=5 -> next cycle: out_address=0x80000000, out_zero=0, out_reg_write=1, out_write_back_destination=5.
REQ-027 SUB A=B=0x1234, branch=1 -> out_address=0, out_zero=1, out_branch=1; SLT A=0xFFFFFFFF, B=1 -> out_address=1.
REQ-028 SW path: ADD alu_src=1, imm=4, A=0x100, read_data_2=0xDEADBEEF, mem_write=1 -> out_address=0x104, out_write_data=0xDEADBEEF, out_mem_write=1.
REQ-029 MULTU 0xFFFFFFFF x 0xFFFFFFFF held under stall -> stall high exactly 33 cycles, all outputs 0 throughout; then MFHI -> 0xFFFFFFFE, MFLO -> 0x00000001.
REQ-030 reset_n=0 pulsed at iteration 10 of MULTU 3x5 -> stall drops the next cycle; a subsequent MFLO returns 0.
REQ-031 in_valid=0 with random controls -> all outputs 0; in_alu_op=13 -> out_address=0, out_zero=1.
